// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128 key schedule generator: WPC words per clock, result held with KEY_DONE.
// Schedule word i is exposed at KEY_SCHEDULE[1407-32*i -: 32].
module aes_key_expander_seq #(
    parameter int unsigned WPC = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            KEY_START,
    input  logic [127:0]    KEY_IN,
    output logic            KEY_BUSY,
    output logic            KEY_DONE,
    output logic [1407:0]   KEY_SCHEDULE
);

    if ((WPC != 1) && (WPC != 4)) begin : gen_wpc_check
        $error("aes_key_expander_seq: WPC must be 1 or 4");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load_key;
    logic        expand_en;
    logic [31:0] w_q [44];
    logic [31:0] lane_w [WPC];
    logic [31:0] prev_w;
    logic [31:0] rot_w;
    logic [31:0] sub_w;

    // Only the first lane can land on a multiple of 4, so one SubWord serves both WPC values.
    assign prev_w = w_q[cnt_q - 6'd1];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};
    assign sub_w  = {sbox(rot_w[31:24]) ^ rcon(cnt_q[5:2]), sbox(rot_w[23:16]),
                     sbox(rot_w[15:8]), sbox(rot_w[7:0])};

    always_comb begin
        logic [31:0] chain;
        chain = prev_w;
        for (int j = 0; j < WPC; j++) begin
            if ((j == 0) && (cnt_q[1:0] == 2'b00)) begin
                chain = sub_w;
            end
            chain     = w_q[cnt_q + 6'(j) - 6'd4] ^ chain;
            lane_w[j] = chain;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        load_key  = 1'b0;
        expand_en = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (KEY_START) begin
                    load_key = 1'b1;
                    cnt_d    = 6'd4;
                    state_d  = StExpand;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            StExpand: begin
                expand_en = 1'b1;
                cnt_d     = cnt_q + 6'(WPC);
                if (cnt_q == 6'(44 - WPC)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 44; i++) begin
                w_q[i] <= '0;
            end
        end else if (load_key) begin
            w_q[0] <= KEY_IN[127:96];
            w_q[1] <= KEY_IN[95:64];
            w_q[2] <= KEY_IN[63:32];
            w_q[3] <= KEY_IN[31:0];
        end else if (expand_en) begin
            for (int j = 0; j < WPC; j++) begin
                w_q[cnt_q + 6'(j)] <= lane_w[j];
            end
        end
    end

    for (genvar i = 0; i < 44; i++) begin : gen_sched
        assign KEY_SCHEDULE[1407 - 32 * i -: 32] = w_q[i];
    end

    assign KEY_BUSY = busy_q;
    assign KEY_DONE = done_q;

endmodule
